// File: rtl/cmu_fp_arbiter_if.sv
// Purpose: bundles the CMU requester, response and shared-FP-unit signals of the arbiter.
// Latency: none, wiring only.
// Backpressure: req side uses valid/ready; responses and FU results are never stalled.
interface cmu_fp_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int DBL_WIDTH = 64
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0]           req_op;
    logic [N_REQ*DBL_WIDTH-1:0] req_a;
    logic [N_REQ*DBL_WIDTH-1:0] req_b;
    logic [N_REQ-1:0]           rsp_valid;
    logic [DBL_WIDTH-1:0]       rsp_data;
    logic                       fu_valid;
    logic                       fu_op;
    logic [DBL_WIDTH-1:0]       fu_a;
    logic [DBL_WIDTH-1:0]       fu_b;
    logic                       fu_finish;
    logic [DBL_WIDTH-1:0]       fu_result;
    logic                       busy;
    logic                       err_orphan;

    // Arbiter side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, fu_finish, fu_result,
        output req_ready, rsp_valid, rsp_data, fu_valid, fu_op, fu_a, fu_b, busy, err_orphan
    );

    // Requester / FP-unit side.
    modport master (
        output req_valid, req_op, req_a, req_b, fu_finish, fu_result,
        input  req_ready, rsp_valid, rsp_data, fu_valid, fu_op, fu_a, fu_b, busy, err_orphan
    );
endinterface

// File: rtl/cmu_fp_arbiter.sv
// Purpose: round-robin sharing of one fp add/mul unit among N_REQ CMU channels, routing results back by tag.
// Latency: issue is combinational in the grant cycle; response appears one cycle after fu_finish.
// Backpressure: req_ready drops when the in-flight tag FIFO is full; responses are never stalled.
module cmu_fp_arbiter #(
    parameter int DBL_WIDTH = 64,
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cmu_fp_arbiter_if.slave bus
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW   = $clog2(TAG_DEPTH);
    localparam int CW   = PW + 1;

    logic [IDXW-1:0]      last_grant_q, last_grant_d;
    logic [IDXW-1:0]      tags_q [TAG_DEPTH];
    logic [IDXW-1:0]      tags_d [TAG_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DBL_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 err_orphan_q, err_orphan_d;

    logic                 gnt_found;
    logic [IDXW-1:0]      gnt_idx;
    int                   cand;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 issue;
    logic                 pop;

    // Round-robin search: first requesting channel at or after last_grant+1, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_grant_q) + i) % N_REQ;
            if (!gnt_found && bus.req_valid[cand[IDXW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDXW-1:0];
            end
        end
    end

    assign fifo_full  = (count_q == CW'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full FIFO blocks issue even when a pop frees a slot in the same cycle.
    assign issue      = rst_n && gnt_found && !fifo_full;
    assign pop        = bus.fu_finish && !fifo_empty;

    assign bus.req_ready  = issue ? (N_REQ'(1) << gnt_idx) : '0;
    assign bus.fu_valid   = |(bus.req_valid & bus.req_ready);
    assign bus.fu_op      = bus.req_op[gnt_idx];
    assign bus.fu_a       = bus.req_a[gnt_idx*DBL_WIDTH +: DBL_WIDTH];
    assign bus.fu_b       = bus.req_b[gnt_idx*DBL_WIDTH +: DBL_WIDTH];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.err_orphan = err_orphan_q;
    assign bus.busy       = (count_q != '0) | (|rsp_valid_q);

    // Next state: tag push on issue, tag pop and response capture on finish, sticky orphan flag.
    always_comb begin
        last_grant_d = last_grant_q;
        tags_d       = tags_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        err_orphan_d = err_orphan_q;

        if (issue) begin
            last_grant_d     = gnt_idx;
            tags_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rsp_valid_d = N_REQ'(1) << tags_q[rd_ptr_q];
            rsp_data_d  = bus.fu_result;
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end

        // A finish with nothing outstanding cannot be routed; flag it and leave the FIFO alone.
        if (bus.fu_finish && fifo_empty) begin
            err_orphan_d = 1'b1;
        end

        case ({issue, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all in-flight tags and gives channel 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDXW'(N_REQ - 1);
            tags_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            tags_q       <= tags_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end
endmodule

// File: tb/tb_cmu_fp_arbiter.sv
// Purpose: directed and random checking of cmu_fp_arbiter against a queue-based reference model.
// Latency: inputs change on the falling edge; outputs are sampled 1-2 time units later.
// Backpressure: the bench plays both the requesters and the shared FP unit.
module tb_cmu_fp_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmu_fp_arbiter_if #(.N_REQ(N), .DBL_WIDTH(W)) bus ();

    cmu_fp_arbiter #(.DBL_WIDTH(W), .N_REQ(N), .TAG_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of owning channels in issue order.
    int           tagq[$];
    int           m_last;
    bit           m_err;
    int           m_rsp_ch;
    logic [W-1:0] m_rsp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        tagq.delete();
        m_last     = N - 1;
        m_err      = 1'b0;
        m_rsp_ch   = -1;
        m_rsp_data = '0;
    endfunction

    function automatic int m_grant();
        if (!rst_n || tagq.size() >= D) return -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (bus.req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_operands();
        for (int c = 0; c < N; c++) begin
            bus.req_a[c*W +: W] = {$urandom, $urandom};
            bus.req_b[c*W +: W] = {$urandom, $urandom};
        end
        bus.req_op = N'($urandom);
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic step();
        int           g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        if (!rst_n) m_reset();
        g         = m_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rsp = '0;
        if (m_rsp_ch >= 0) exp_rsp[m_rsp_ch] = 1'b1;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("fu_valid", 64'(bus.fu_valid), 64'(g >= 0));
        if (g >= 0) begin
            chk("fu_op", 64'(bus.fu_op), 64'(bus.req_op[g]));
            chk("fu_a", bus.fu_a, bus.req_a[g*W +: W]);
            chk("fu_b", bus.fu_b, bus.req_b[g*W +: W]);
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        chk("rsp_data", bus.rsp_data, m_rsp_data);
        chk("busy", 64'(bus.busy), 64'(tagq.size() != 0 || m_rsp_ch >= 0));
        chk("err_orphan", 64'(bus.err_orphan), 64'(m_err));
        @(posedge clk);
        if (rst_n) begin
            m_rsp_ch = -1;
            if (bus.fu_finish) begin
                if (tagq.size() > 0) begin
                    m_rsp_ch   = tagq.pop_front();
                    m_rsp_data = bus.fu_result;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (g >= 0) begin
                tagq.push_back(g);
                m_last = g;
            end
        end
        @(negedge clk);
    endtask

    logic [N-1:0] exp_seq [3];
    logic [W-1:0] res_seq [3];

    initial begin
        m_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.fu_finish = 1'b0;
        bus.fu_result = '0;
        @(negedge clk);

        // Reset state; requests are ignored while in reset.
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_fu_valid", 64'(bus.fu_valid), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_err", 64'(bus.err_orphan), 64'h0);
        chk("rst_rsp_data", bus.rsp_data, 64'h0);
        step();
        bus.req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        // Single add: 1.0 + 2.0, unit answers 3.0 three cycles after issue.
        bus.req_valid        = 4'b0001;
        bus.req_op[0]        = 1'b0;
        bus.req_a[0*W +: W]  = 64'h3FF0000000000000;
        bus.req_b[0*W +: W]  = 64'h4000000000000000;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h1);
        chk("single_fu_a", bus.fu_a, 64'h3FF0000000000000);
        step();
        bus.req_valid = '0;
        step();
        step();
        bus.fu_finish = 1'b1;
        bus.fu_result = 64'h4008000000000000;
        step();
        bus.fu_finish = 1'b0;
        #1;
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("single_rsp_data", bus.rsp_data, 64'h4008000000000000);
        step();
        step();

        // Round robin from reset with all channels requesting fills the FIFO.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rand_operands();
            #1;
            chk("rr_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
            step();
        end
        #1;
        chk("rr_full_ready", 64'(bus.req_ready), 64'h0);
        step();

        // Full FIFO with a finish in the same cycle: no issue until the next cycle.
        bus.req_valid = 4'b0100;
        bus.fu_finish = 1'b1;
        bus.fu_result = {$urandom, $urandom};
        #1;
        chk("full_fin_ready", 64'(bus.req_ready), 64'h0);
        step();
        bus.fu_finish = 1'b0;
        #1;
        chk("full_next_ready", 64'(bus.req_ready), 64'h4);
        chk("full_rsp_ch0", 64'(bus.rsp_valid), 64'h1);
        step();
        bus.req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            bus.fu_finish = 1'b1;
            bus.fu_result = {$urandom, $urandom};
            step();
        end
        bus.fu_finish = 1'b0;
        step();

        // In-order routing: ch3, ch1, ch3.
        exp_seq[0] = 4'b1000;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = exp_seq[k];
            rand_operands();
            #1;
            chk("order_issue", 64'(bus.req_ready), 64'(exp_seq[k]));
            step();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            res_seq[k]    = {$urandom, $urandom};
            bus.fu_finish = 1'b1;
            bus.fu_result = res_seq[k];
            step();
            bus.fu_finish = 1'b0;
            #1;
            chk("order_rsp_valid", 64'(bus.rsp_valid), 64'(exp_seq[k]));
            chk("order_rsp_data", bus.rsp_data, res_seq[k]);
            step();
        end

        // Orphan finish: sticky error, no response.
        bus.fu_finish = 1'b1;
        step();
        bus.fu_finish = 1'b0;
        #1;
        chk("orphan_err", 64'(bus.err_orphan), 64'h1);
        chk("orphan_rsp", 64'(bus.rsp_valid), 64'h0);
        step();
        step();
        step();
        #1;
        chk("orphan_sticky", 64'(bus.err_orphan), 64'h1);

        // Reset with three ops in flight.
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'h0);
        chk("midrst_err", 64'(bus.err_orphan), 64'h0);
        chk("midrst_ready", 64'(bus.req_ready), 64'h0);
        chk("midrst_fu_valid", 64'(bus.fu_valid), 64'h0);
        step();
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.fu_finish = 1'b1;
        step();
        bus.fu_finish = 1'b0;
        #1;
        chk("postrst_orphan", 64'(bus.err_orphan), 64'h1);
        bus.req_valid = 4'b1111;
        #1;
        chk("postrst_ch0_first", 64'(bus.req_ready), 64'h1);
        step();

        // Back-to-back issues from a lone requester.
        rst_n = 1'b0;
        bus.req_valid = '0;
        step();
        rst_n = 1'b1;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            rand_operands();
            #1;
            chk("b2b_ready", 64'(bus.req_ready), 64'h2);
            step();
        end

        // Random traffic with occasional reset pulses.
        for (int k = 0; k < 1500; k++) begin
            bus.req_valid = N'($urandom);
            rand_operands();
            bus.fu_finish = ($urandom_range(0, 99) < 45);
            bus.fu_result = {$urandom, $urandom};
            rst_n         = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.fu_finish = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmu_fp_arbiter.md
CMU_FP_ARBITER -- requirements
Module: cmu_fp_arbiter

Interface
REQ-001 SHALL have parameter DBL_WIDTH, default 64, operand/result width in bits (IEEE-754 double).
REQ-002 SHALL have parameter N_REQ, default 4, number of CMU requester channels (2..8).
REQ-003 SHALL have parameter TAG_DEPTH, default 8, in-flight operation capacity (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-channel operation request.
REQ-007 SHALL have port req_ready  output  N_REQ  per-channel accept; one-hot or zero.
REQ-008 SHALL have port req_op  input  N_REQ  per-channel opcode: 0 = add, 1 = multiply.
REQ-009 SHALL have port req_a  input  N_REQ*DBL_WIDTH  per-channel operand A; channel i at bits [i*DBL_WIDTH +: DBL_WIDTH].
REQ-010 SHALL have port req_b  input  N_REQ*DBL_WIDTH  per-channel operand B, same packing.
REQ-011 SHALL have port rsp_valid  output  N_REQ  one-cycle result strobe to the owning channel.
REQ-012 SHALL have port rsp_data  output  DBL_WIDTH  result, shared by all channels, qualified by rsp_valid.
REQ-013 SHALL have port fu_valid  output  1  issue strobe to the shared fp_adder/fp_multiplier unit.
REQ-014 SHALL have port fu_op  output  1  opcode of the issued operation.
REQ-015 SHALL have ports fu_a, fu_b  output  DBL_WIDTH  operands of the issued operation.
REQ-016 SHALL have port fu_finish  input  1  completion strobe from the shared unit; completions arrive in issue order.
REQ-017 SHALL have port fu_result  input  DBL_WIDTH  result qualified by fu_finish.
REQ-018 SHALL have port busy  output  1  high while any operation is in flight or a response is pending.
REQ-019 SHALL have port err_orphan  output  1  sticky: fu_finish seen with no operation in flight.

Function
REQ-020 SHALL grant at most one channel per cycle, round-robin starting at (last_grant+1) mod N_REQ among channels with req_valid=1.
REQ-021 SHALL drive req_ready combinationally: 1 only for the granted channel, and only when the tag FIFO is not full.
REQ-022 SHALL drive fu_valid = |(req_valid & req_ready), with fu_op/fu_a/fu_b muxed combinationally from the granted channel; operands are don't-care when fu_valid=0.
REQ-023 SHALL update last_grant only in a cycle in which a grant occurs.
REQ-024 SHALL push the granted channel index into a TAG_DEPTH-entry tag FIFO on each issue.
REQ-025 SHALL pop the FIFO head on each fu_finish when the FIFO is non-empty.
REQ-026 SHALL block issue when the FIFO is full, including a cycle with fu_finish=1; simultaneous push and pop in a non-full, non-empty FIFO leave occupancy unchanged.
REQ-027 SHALL register the response: fu_finish at cycle t -> rsp_valid[head tag]=1 and rsp_data=fu_result at cycle t+1, for exactly one cycle.
REQ-028 SHALL hold rsp_data at its last value when rsp_valid=0.
REQ-029 SHALL, on fu_finish with an empty FIFO, set err_orphan=1, generate no rsp_valid, and leave FIFO pointers unchanged.
REQ-030 SHALL assert busy = (FIFO occupancy != 0) | (|rsp_valid).
REQ-031 SHALL accept back-to-back issues from the same channel when it is the only requester.
REQ-032 SHALL not backpressure responses; requesters must accept rsp_valid unconditionally.

Reset
REQ-033 SHALL, while rst_n=0: FIFO empty, last_grant=N_REQ-1 (so channel 0 has first priority), rsp_valid=0, rsp_data=0, err_orphan=0, busy=0.
REQ-034 SHALL, for an rst_n assertion mid-operation, discard all in-flight tags; fu_finish after reset release with an empty FIFO sets err_orphan per REQ-029.
REQ-035 SHALL force req_ready=0 and fu_valid=0 while rst_n=0.

Verification
REQ-036 Single request: after reset, req_valid=0001, op=add, a=1.0, b=2.0; unit returns 3.0 three cycles later -> req_ready=0001 in the same cycle, fu_valid=1, rsp_valid=0001 with rsp_data=0x4008000000000000 one cycle after fu_finish.
REQ-037 Round-robin: req_valid=1111 held for 8 cycles with no fu_finish -> grants 0,1,2,3,0,1,2,3; FIFO full after 8 grants; 9th cycle req_ready=0000.
REQ-038 Full with simultaneous finish: FIFO full, fu_finish=1 and req_valid=0100 in the same cycle -> no issue that cycle; grant to channel 2 in the next cycle; response goes to channel 0.
REQ-039 In-order routing: issue ch3, ch1, ch3 in that order; three fu_finish pulses -> rsp_valid sequence 1000, 0010, 1000 with matching rsp_data.
REQ-040 Orphan: fu_finish=1 with FIFO empty -> err_orphan=1 and held; rsp_valid stays 0000; cleared only by rst_n.
REQ-041 Reset mid-flight: 3 ops in flight, pulse rst_n low -> busy=0, last_grant=N_REQ-1 and channel 0 first granted after release.
